keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Column-driving scanner for the 4x4 matrix keypad; the active counterpart of the press-detection logic that only reads the debounced row lines. It walks a single low column across the keypad, samples the four debounced, active-low row inputs at the end of each column dwell, and encodes the first pressed key into a 4-bit code. It issues a one-cycle valid strobe per press, then holds the column until the key is released. It sits between the row debouncers and the key-consuming logic.

## Interface
- SCAN_TICKS, 1000, clock cycles each column is driven before advancing (>= 2)
- RELEASE_TICKS, 1000, consecutive all-high row cycles required to declare release (>= 1)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- row_i  in  4  debounced row lines, active-low, bit n = row n
- col_o  out  4  column drive, one-cold, active-low, bit n = column n
- key_o  out  4  key code {row_idx[1:0], col_idx[1:0]}, held until next capture
- valid_o  out  1  one-cycle strobe, key_o valid in the same cycle
- busy_o  out  1  high from capture until release is confirmed

## Operation
- One clock, `clk`; reset `rst` is synchronous and active-high.
- All outputs registered. Reset values: col_o=4'b1110, key_o=4'h0, valid_o=0, busy_o=0, state SCAN, dwell and release counters 0.
- SCAN:
  - The dwell counter runs 0..SCAN_TICKS-1; busy_o=0.
  - On the edge where dwell==SCAN_TICKS-1 and row_i==4'b1111: advance the column 0->1->2->3->0 (col_o 1110->1101->1011->0111->1110) and clear the dwell counter.
  - On the edge where dwell==SCAN_TICKS-1 and row_i!=4'b1111: capture key_o={lowest-index low row, current column}, hold col_o, go to REPORT.
  - Rows are ignored at every other dwell count; this is the settling time after a column change.
- REPORT:
  - Lasts exactly one cycle; valid_o=1, busy_o=1. Next state is WAIT_RELEASE.
- WAIT_RELEASE:
  - col_o is held; busy_o=1; valid_o=0.
  - The release counter increments on each cycle row_i==4'b1111 and clears to 0 on any cycle with a low row.
  - On the edge where the counter==RELEASE_TICKS-1 and row_i==4'b1111: go to SCAN, advance to the next column, clear both counters, set busy_o=0.
- Multiple rows low in the sampled column: the lowest row index wins. Presses in other columns are invisible until scanned.
- rst asserted in any state, including REPORT: all reset values apply at the next edge, and no valid_o is emitted.

## Timing
- Capture latency: a row sampled low at the dwell-end edge produces key_o and valid_o=1 in the immediately following cycle; key_o and valid_o change on the same edge.
- Exactly one valid_o pulse per press, regardless of hold duration.
- Full scan period: 4*SCAN_TICKS cycles with no key pressed.
- After release, the first new sample occurs SCAN_TICKS cycles after returning to SCAN, on the next column.
- Release timing: busy_o falls on the edge RELEASE_TICKS-1 cycles after the first cycle of an uninterrupted all-high row run.

## Test plan
Parameters for all scenarios: SCAN_TICKS=4, RELEASE_TICKS=3.
- Reset, idle: rst high for 2 cycles, row_i=1111 -> col_o=1110, key_o=0, valid_o=0, busy_o=0. After rst falls, col_o steps 1110->1101->1011->0111->1110, one step every 4 cycles; valid_o never asserts.
- Single press: row_i=1011 only while col_o=1101 -> one valid_o pulse with key_o=4'h9, busy_o=1, col_o held at 1101.
- Long hold and release: row 2 held low for 20 cycles, then row_i=1111 -> no second valid_o. busy_o falls 2 cycles after the first high cycle, col_o becomes 1011, key_o stays 4'h9.
- Release bounce: during WAIT_RELEASE, row_i high 2 cycles, low 1 cycle, then high -> release count restarts, busy_o falls only after 3 uninterrupted high cycles, no extra valid_o.
- Multi-row: row_i=0101 while col_o=0111 -> key_o=4'h7 (row 1, column 3), single valid_o.
- Reset mid-hold: rst pulsed during WAIT_RELEASE with the key still held -> reset values on the next edge. Scanning restarts at column 0; a new valid_o appears only when the still-held key's column is sampled.

Source files
------------

// File: rtl/keypad_scanner.sv
// Column-driving 4x4 keypad scanner: walks a single low column, samples debounced
// active-low rows at the end of each dwell, reports one key code per press.
//
// state        | meaning
// SCAN         | driving a column, sampling rows at the last dwell count
// REPORT       | one-cycle valid_o strobe with the captured key code
// WAIT_RELEASE | column held until rows stay high for RELEASE_TICKS cycles
module keypad_scanner #(
  parameter int SCAN_TICKS    = 1000,
  parameter int RELEASE_TICKS = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [3:0] key_o,
  output logic       valid_o,
  output logic       busy_o
);

  localparam int DW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int RW = (RELEASE_TICKS > 1) ? $clog2(RELEASE_TICKS) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_TICKS - 1);
  localparam logic [RW-1:0] REL_LAST   = RW'(RELEASE_TICKS - 1);

  typedef enum logic [1:0] {SCAN, REPORT, WAIT_RELEASE} state_t;

  state_t        state_q;
  logic [DW-1:0] dwell_q;
  logic [RW-1:0] rel_q;
  logic [1:0]    col_idx_q;
  logic [3:0]    col_q;
  logic [3:0]    key_q;
  logic          valid_q;
  logic          busy_q;

  logic       rows_idle;
  logic [1:0] low_row;
  logic [1:0] col_idx_d;
  logic [3:0] col_d;

  // Lowest-index low row wins when several rows are pressed in one column.
  always_comb begin
    rows_idle = &row_i;
    if (!row_i[0])      low_row = 2'd0;
    else if (!row_i[1]) low_row = 2'd1;
    else if (!row_i[2]) low_row = 2'd2;
    else                low_row = 2'd3;
    col_idx_d = col_idx_q + 2'd1;
    col_d     = ~(4'b0001 << col_idx_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SCAN;
      dwell_q   <= '0;
      rel_q     <= '0;
      col_idx_q <= 2'd0;
      col_q     <= 4'b1110;
      key_q     <= 4'h0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        SCAN: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          if (dwell_q == DWELL_LAST) begin
            dwell_q <= '0;
            if (rows_idle) begin
              col_idx_q <= col_idx_d;
              col_q     <= col_d;
            end else begin
              key_q   <= {low_row, col_idx_q};
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= REPORT;
            end
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end
        REPORT: begin
          valid_q <= 1'b0;
          rel_q   <= '0;
          state_q <= WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (!rows_idle) begin
            rel_q <= '0;
          end else if (rel_q == REL_LAST) begin
            rel_q     <= '0;
            dwell_q   <= '0;
            busy_q    <= 1'b0;
            col_idx_q <= col_idx_d;
            col_q     <= col_d;
            state_q   <= SCAN;
          end else begin
            rel_q <= rel_q + 1'b1;
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign col_o   = col_q;
  assign key_o   = key_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives the rows from the
// driven column, and a timeline model predicts every output cycle by cycle.
module tb_keypad_scanner;
  localparam int ST = 4;
  localparam int RT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_i = 4'hF;
  logic [3:0] col_o, key_o;
  logic       valid_o, busy_o;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] held = '0;  // bit r*4+c = key at row r, column c pressed

  keypad_scanner #(.SCAN_TICKS(ST), .RELEASE_TICKS(RT)) dut (
    .clk(clk), .rst(rst), .row_i(row_i), .col_o(col_o),
    .key_o(key_o), .valid_o(valid_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Reference timeline: m_t cycles into the current column, m_run high cycles in a row.
  int m_t = 0, m_col = 0, m_mode = 0, m_run = 0;
  logic [3:0] m_key = 4'h0;
  logic m_valid = 1'b0, m_busy = 1'b0;

  function automatic int first_low(logic [3:0] r);
    for (int i = 0; i < 4; i++) if (!r[i]) return i;
    return 0;
  endfunction

  function automatic logic [3:0] rows_for(logic [3:0] col, logic [15:0] keys);
    logic [3:0] r;
    r = 4'hF;
    for (int c = 0; c < 4; c++)
      if (col[c] === 1'b0)
        for (int k = 0; k < 4; k++) if (keys[k*4+c]) r[k] = 1'b0;
    return r;
  endfunction

  function automatic logic [10:0] exp_vec();
    logic [3:0] c;
    c = 4'hF;
    c[m_col] = 1'b0;
    return {c, m_key, m_valid, m_busy};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_t = 0; m_col = 0; m_mode = 0; m_run = 0;
      m_key = 4'h0; m_valid = 1'b0; m_busy = 1'b0;
    end else if (m_mode == 0) begin
      if (m_t == ST - 1) begin
        m_t = 0;
        if (row_i == 4'hF) m_col = (m_col + 1) % 4;
        else begin
          m_key = {2'(first_low(row_i)), 2'(m_col)};
          m_valid = 1'b1; m_busy = 1'b1; m_mode = 1;
        end
      end else m_t++;
    end else if (m_mode == 1) begin
      m_valid = 1'b0; m_mode = 2; m_run = 0;
    end else begin
      if (row_i == 4'hF) begin
        m_run++;
        if (m_run == RT) begin
          m_mode = 0; m_col = (m_col + 1) % 4; m_t = 0; m_run = 0; m_busy = 1'b0;
        end
      end else m_run = 0;
    end
  end

  task automatic apply();
    row_i = rows_for(col_o, held);
  endtask

  task automatic cycle();
    @(negedge clk);
    row_i = rows_for(col_o, held);
  endtask

  task automatic test_reset();
    int nval;
    rst = 1'b1; held = '0; row_i = 4'hF;
    cycle(); cycle();
    vectors++; if (col_o !== 4'b1110) begin miscompares++; $display("FAIL reset_col: got %b want 1110", col_o); end
    vectors++; if (key_o !== 4'h0) begin miscompares++; $display("FAIL reset_key: got %h want 0", key_o); end
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    rst = 1'b0;
    nval = 0;
    for (int i = 0; i < 8 * ST; i++) begin
      cycle();
      if (valid_o === 1'b1) nval++;
      if (i == ST - 1) begin
        vectors++; if (col_o !== 4'b1101) begin miscompares++; $display("FAIL idle_step1: got %b want 1101", col_o); end
      end
      if (i == 4 * ST - 1) begin
        vectors++; if (col_o !== 4'b1110) begin miscompares++; $display("FAIL idle_wrap: got %b want 1110", col_o); end
      end
      vectors++;
      if ({col_o, key_o, valid_o, busy_o} !== exp_vec()) begin
        miscompares++; $display("FAIL idle_cyc%0d: got %h want %h", i, {col_o, key_o, valid_o, busy_o}, exp_vec());
      end
    end
    vectors++; if (nval != 0) begin miscompares++; $display("FAIL idle_novalid: got %0d pulses want 0", nval); end
  endtask

  task automatic wait_valid(input string name, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      cycle();
      vectors++;
      if ({col_o, key_o, valid_o, busy_o} !== exp_vec()) begin
        miscompares++; $display("FAIL %s_cyc%0d: got %h want %h", name, i, {col_o, key_o, valid_o, busy_o}, exp_vec());
      end
      if (valid_o === 1'b1) seen = 1;
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL %s_timeout: no valid_o within %0d cycles", name, budget); end
  endtask

  task automatic test_single_press();
    int guard;
    held = '0; apply();
    guard = 0;
    while (col_o !== 4'b1101 && guard < 5 * ST) begin cycle(); guard++; end
    vectors++; if (col_o !== 4'b1101) begin miscompares++; $display("FAIL single_reach_col1: got %b want 1101", col_o); end
    held[2*4+1] = 1'b1; apply();
    wait_valid("single", 2 * ST);
    vectors++; if (key_o !== 4'h9) begin miscompares++; $display("FAIL single_key: got %h want 9", key_o); end
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b want 1", busy_o); end
    vectors++; if (col_o !== 4'b1101) begin miscompares++; $display("FAIL single_col: got %b want 1101", col_o); end
  endtask

  task automatic test_long_hold();
    int nval, k;
    nval = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (valid_o === 1'b1) nval++;
      vectors++;
      if ({col_o, key_o, valid_o, busy_o} !== exp_vec()) begin
        miscompares++; $display("FAIL hold_cyc%0d: got %h want %h", i, {col_o, key_o, valid_o, busy_o}, exp_vec());
      end
    end
    vectors++; if (nval != 0) begin miscompares++; $display("FAIL hold_extra_valid: got %0d want 0", nval); end
    held = '0; apply();
    k = 0;
    while (k < 10) begin
      cycle(); k++;
      vectors++;
      if ({col_o, key_o, valid_o, busy_o} !== exp_vec()) begin
        miscompares++; $display("FAIL release_cyc%0d: got %h want %h", k, {col_o, key_o, valid_o, busy_o}, exp_vec());
      end
      if (busy_o === 1'b0) break;
    end
    vectors++; if (k != RT) begin miscompares++; $display("FAIL release_latency: got %0d cycles want %0d", k, RT); end
    vectors++; if (col_o !== 4'b1011) begin miscompares++; $display("FAIL release_col: got %b want 1011", col_o); end
    vectors++; if (key_o !== 4'h9) begin miscompares++; $display("FAIL release_key: got %h want 9", key_o); end
  endtask

  task automatic test_release_bounce();
    int nval;
    held = '0; held[0*4+3] = 1'b1; apply();
    wait_valid("bounce_press", 4 * ST + 2);
    vectors++; if (key_o !== 4'h3) begin miscompares++; $display("FAIL bounce_key: got %h want 3", key_o); end
    cycle();
    nval = 0;
    held = '0; apply(); cycle(); cycle();
    held[3] = 1'b1; apply(); cycle();
    held = '0; apply(); cycle(); cycle();
    if (valid_o === 1'b1) nval++;
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL bounce_early_release: busy got %b want 1", busy_o); end
    vectors++;
    if ({col_o, key_o, valid_o, busy_o} !== exp_vec()) begin
      miscompares++; $display("FAIL bounce_mid: got %h want %h", {col_o, key_o, valid_o, busy_o}, exp_vec());
    end
    cycle();
    if (valid_o === 1'b1) nval++;
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL bounce_release: busy got %b want 0", busy_o); end
    vectors++; if (col_o !== 4'b1110) begin miscompares++; $display("FAIL bounce_col: got %b want 1110", col_o); end
    vectors++; if (nval != 0) begin miscompares++; $display("FAIL bounce_valid: got %0d pulses want 0", nval); end
  endtask

  task automatic test_multi_row();
    int guard;
    held = '0; apply();
    guard = 0;
    while (col_o !== 4'b0111 && guard < 5 * ST) begin cycle(); guard++; end
    vectors++; if (col_o !== 4'b0111) begin miscompares++; $display("FAIL multi_reach_col3: got %b want 0111", col_o); end
    held[1*4+3] = 1'b1; held[3*4+3] = 1'b1; apply();
    vectors++; if (row_i !== 4'b0101) begin miscompares++; $display("FAIL multi_rows: got %b want 0101", row_i); end
    wait_valid("multi", 2 * ST);
    vectors++; if (key_o !== 4'h7) begin miscompares++; $display("FAIL multi_key: got %h want 7", key_o); end
    cycle();
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL multi_single_pulse: got %b want 0", valid_o); end
    held = '0; apply();
    for (int i = 0; i < RT + 1; i++) begin
      cycle();
      vectors++;
      if ({col_o, key_o, valid_o, busy_o} !== exp_vec()) begin
        miscompares++; $display("FAIL multi_rel_cyc%0d: got %h want %h", i, {col_o, key_o, valid_o, busy_o}, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    int k;
    held = '0; held[3*4+2] = 1'b1; apply();
    wait_valid("midhold_press", 4 * ST + 2);
    vectors++; if (key_o !== 4'hE) begin miscompares++; $display("FAIL midhold_key: got %h want e", key_o); end
    cycle(); cycle(); cycle();
    rst = 1'b1; cycle();
    vectors++;
    if ({col_o, key_o, valid_o, busy_o} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL midhold_reset: got %h want %h", {col_o, key_o, valid_o, busy_o}, {4'b1110, 4'h0, 1'b0, 1'b0});
    end
    rst = 1'b0;
    k = 0;
    while (k < 5 * ST && valid_o !== 1'b1) begin
      cycle(); k++;
      vectors++;
      if ({col_o, key_o, valid_o, busy_o} !== exp_vec()) begin
        miscompares++; $display("FAIL midhold_rescan_cyc%0d: got %h want %h", k, {col_o, key_o, valid_o, busy_o}, exp_vec());
      end
    end
    vectors++; if (k != 3 * ST) begin miscompares++; $display("FAIL midhold_relatency: got %0d cycles want %0d", k, 3 * ST); end
    vectors++; if (key_o !== 4'hE) begin miscompares++; $display("FAIL midhold_rekey: got %h want e", key_o); end
    rst = 1'b1; cycle();
    vectors++; if (valid_o !== 1'b0 || busy_o !== 1'b0 || col_o !== 4'b1110) begin
      miscompares++; $display("FAIL report_reset: got valid %b busy %b col %b want 0 0 1110", valid_o, busy_o, col_o);
    end
    rst = 1'b0; held = '0; apply();
    for (int i = 0; i < 2 * ST; i++) begin
      cycle();
      vectors++;
      if ({col_o, key_o, valid_o, busy_o} !== exp_vec()) begin
        miscompares++; $display("FAIL post_reset_cyc%0d: got %h want %h", i, {col_o, key_o, valid_o, busy_o}, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int r, nval, mval;
    nval = 0; mval = 0;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) held[$urandom_range(0, 15)] ^= 1'b1;
      else if (r >= 96) held = '0;
      rst = ($urandom_range(0, 249) == 0);
      apply();
      cycle();
      if (valid_o === 1'b1) nval++;
      if (m_valid) mval++;
      vectors++;
      if ({col_o, key_o, valid_o, busy_o} !== exp_vec()) begin
        miscompares++; $display("FAIL random_cyc%0d: got %h want %h", i, {col_o, key_o, valid_o, busy_o}, exp_vec());
      end
    end
    rst = 1'b0;
    vectors++; if (nval != mval) begin miscompares++; $display("FAIL random_pulses: got %0d want %0d", nval, mval); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_long_hold();
    test_release_bounce();
    test_multi_row();
    test_reset_mid_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
